// File: rtl/wave_ctrl_pkg.sv
// Shared constants and types for the wave_ctrl block: parameter defaults,
// the debounce state encoding and the step clamp limits.
package wave_ctrl_pkg;

  localparam int DEF_NCH      = 2;
  localparam int DEF_PHASE_W  = 32;
  localparam int DEF_AMP_W    = 8;
  localparam int DEF_STEP_DEF = 10000;
  localparam int DEF_STEP_INC = 1000;
  localparam int DEF_FINE_INC = 100;
  localparam int DEF_DEB_CYC  = 16;
  localparam int DEF_AMP_SLEW = 1;

  // Clamp limits for the base step and the final output step
  localparam int DEF_STEP_MIN = 1000;
  localparam int DEF_STEP_MAX = 1000000;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/wave_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce
  import wave_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  // The cycle that enters COUNTING is the first differing cycle, so it counts as 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      STABLE: begin
        if (sync2_q != level_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNTING: begin
        if (sync2_q == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_o = press_q;

endmodule

// File: rtl/wave_ctrl.sv
// Multi-channel waveform controller: buttons nudge the selected channel's base
// step, switches set its fine step and amplitude target, amplitude slews.
module wave_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int AMP_W    = DEF_AMP_W,
  parameter int STEP_DEF = DEF_STEP_DEF,
  parameter int STEP_INC = DEF_STEP_INC,
  parameter int STEP_MIN = DEF_STEP_MIN,
  parameter int STEP_MAX = DEF_STEP_MAX,
  parameter int FINE_INC = DEF_FINE_INC,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int AMP_SLEW = DEF_AMP_SLEW
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [3:0]                           switches,
  input  logic                                 button_freq_inc,
  input  logic                                 button_freq_dec,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
  output logic [NCH*PHASE_W-1:0]               phase_step,
  output logic [NCH*AMP_W-1:0]                 amplitude,
  output logic [NCH-1:0]                       update
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = PHASE_W;
  localparam int AW   = AMP_W;

  localparam logic [PW-1:0] STEP_DEF_N = PW'(STEP_DEF);
  localparam logic [PW-1:0] STEP_MIN_N = PW'(STEP_MIN);
  localparam logic [PW-1:0] STEP_MAX_N = PW'(STEP_MAX);
  localparam logic [PW-1:0] STEP_INC_N = PW'(STEP_INC);
  localparam logic [PW:0]   STEP_INC_W = (PW+1)'(STEP_INC);
  localparam logic [PW:0]   STEP_MAX_W = (PW+1)'(STEP_MAX);
  localparam logic [PW:0]   FINE_INC_W = (PW+1)'(FINE_INC);
  localparam logic [PW:0]   DEC_FLOOR_W = (PW+1)'(STEP_MIN + STEP_INC);
  localparam logic [AW-1:0] SLEW_N     = AW'(AMP_SLEW);

  logic incPress, decPress;
  logic incOnly, decOnly;
  logic selValid;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (button_freq_inc),
    .press_o (incPress)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dec (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (button_freq_dec),
    .press_o (decPress)
  );

  // Simultaneous inc and dec presses cancel out
  assign incOnly  = incPress & ~decPress;
  assign decOnly  = decPress & ~incPress;
  assign selValid = (int'(ch_sel) < NCH);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic          sel;
    logic [PW-1:0] base_q, base_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    fine_q, fine_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] amp_q, amp_d;
    logic [AW-1:0] gap;
    logic          upd_q, upd_d;
    logic [PW:0]   baseUp;
    logic [PW:0]   stepSum;

    assign sel = selValid && (ch_sel == CH_W'(k));

    // Sums are taken one bit wider so the clamps see the true value, never a wrap
    always_comb begin
      base_d  = base_q;
      fine_d  = fine_q;
      tgt_d   = tgt_q;
      gap     = '0;
      amp_d   = amp_q;
      baseUp  = {1'b0, base_q} + STEP_INC_W;
      if (sel) begin
        fine_d = switches;
        tgt_d  = (switches == 4'd0) ? '1 : (AW'(switches) << (AMP_W - 4));
        if (incOnly) begin
          base_d = (baseUp > STEP_MAX_W) ? STEP_MAX_N : baseUp[PW-1:0];
        end else if (decOnly) begin
          base_d = ({1'b0, base_q} < DEC_FLOOR_W) ? STEP_MIN_N : (base_q - STEP_INC_N);
        end
      end

      stepSum = {1'b0, base_q} + ((PW+1)'(fine_q) * FINE_INC_W);
      phase_d = (stepSum > STEP_MAX_W) ? STEP_MAX_N : stepSum[PW-1:0];

      if (tgt_q > amp_q) begin
        gap   = tgt_q - amp_q;
        amp_d = amp_q + ((gap > SLEW_N) ? SLEW_N : gap);
      end else if (tgt_q < amp_q) begin
        gap   = amp_q - tgt_q;
        amp_d = amp_q - ((gap > SLEW_N) ? SLEW_N : gap);
      end

      upd_d = (phase_d != phase_q) || (amp_d != amp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        base_q  <= STEP_DEF_N;
        phase_q <= STEP_DEF_N;
        fine_q  <= '0;
        tgt_q   <= '1;
        amp_q   <= '1;
        upd_q   <= 1'b0;
      end else begin
        base_q  <= base_d;
        phase_q <= phase_d;
        fine_q  <= fine_d;
        tgt_q   <= tgt_d;
        amp_q   <= amp_d;
        upd_q   <= upd_d;
      end
    end

    assign phase_step[k*PW +: PW] = phase_q;
    assign amplitude[k*AW +: AW]  = amp_q;
    assign update[k]              = upd_q;
  end

endmodule

// File: tb/tb_wave_ctrl.sv
// Directed bench for wave_ctrl with NCH=2, DEB_CYC=4, AMP_SLEW=1;
// expected values are hand-computed from the default step constants.
module tb_wave_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  switches;
  logic        binc, bdec;
  logic [0:0]  chSel;
  logic [63:0] phaseStep;
  logic [15:0] amplitude;
  logic [1:0]  update;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wave_ctrl #(.NCH(2), .DEB_CYC(4), .AMP_SLEW(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .switches        (switches),
    .button_freq_inc (binc),
    .button_freq_dec (bdec),
    .ch_sel          (chSel),
    .phase_step      (phaseStep),
    .amplitude       (amplitude),
    .update          (update)
  );

  task automatic pressButton(input bit isInc, input int hi, input int lo);
    if (isInc) binc = 1'b1; else bdec = 1'b1;
    repeat (hi) @(negedge clk);
    binc = 1'b0;
    bdec = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; switches = 4'd0; binc = 1'b0; bdec = 1'b0; chSel = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (phaseStep[31:0] !== 32'd10000) begin mismatched++; $display("[TB] FAIL reset_phase0 got %0d want 10000", phaseStep[31:0]); end
    compared++; if (phaseStep[63:32] !== 32'd10000) begin mismatched++; $display("[TB] FAIL reset_phase1 got %0d want 10000", phaseStep[63:32]); end
    compared++; if (amplitude !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL reset_amp got %h want ffff", amplitude); end
    compared++; if (update !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_update got %b want 00", update); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (phaseStep[31:0] !== 32'd10000 || update !== 2'b00) begin mismatched++; $display("[TB] FAIL post_reset got phase0=%0d upd=%b want 10000/00", phaseStep[31:0], update); end
  endtask

  task automatic test_inc_press;
    int pulses = 0;
    int pulses1 = 0;
    int firstIdx = -1;
    chSel = 1'b0;
    binc = 1'b1;
    repeat (3) @(negedge clk);
    binc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (update[0]) pulses++;
    end
    compared++; if (pulses != 0 || phaseStep[31:0] !== 32'd10000) begin mismatched++; $display("[TB] FAIL glitch_rejected got pulses=%0d phase0=%0d want 0/10000", pulses, phaseStep[31:0]); end
    binc = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 11) binc = 1'b0;
      if (update[1]) pulses1++;
      if (update[0]) begin
        pulses++;
        if (firstIdx < 0) firstIdx = i;
        compared++; if (phaseStep[31:0] !== 32'd11000) begin mismatched++; $display("[TB] FAIL inc_aligned got phase0=%0d want 11000", phaseStep[31:0]); end
      end
    end
    compared++; if (pulses != 1) begin mismatched++; $display("[TB] FAIL inc_one_press got %0d pulses want 1", pulses); end
    compared++; if (firstIdx != 8) begin mismatched++; $display("[TB] FAIL inc_latency got cycle %0d want 8", firstIdx); end
    compared++; if (phaseStep[31:0] !== 32'd11000) begin mismatched++; $display("[TB] FAIL inc_phase0 got %0d want 11000", phaseStep[31:0]); end
    compared++; if (phaseStep[63:32] !== 32'd10000 || pulses1 != 0) begin mismatched++; $display("[TB] FAIL inc_ch1_untouched got phase1=%0d upd1=%0d want 10000/0", phaseStep[63:32], pulses1); end
  endtask

  task automatic test_dec_clamp;
    chSel = 1'b1;
    for (int i = 0; i < 5; i++) pressButton(1'b0, 7, 7);
    compared++; if (phaseStep[63:32] !== 32'd5000) begin mismatched++; $display("[TB] FAIL dec_mid got %0d want 5000", phaseStep[63:32]); end
    for (int i = 0; i < 5; i++) pressButton(1'b0, 7, 7);
    compared++; if (phaseStep[63:32] !== 32'd1000) begin mismatched++; $display("[TB] FAIL dec_clamp got %0d want 1000", phaseStep[63:32]); end
    compared++; if (phaseStep[31:0] !== 32'd11000) begin mismatched++; $display("[TB] FAIL dec_ch0_untouched got %0d want 11000", phaseStep[31:0]); end
  endtask

  task automatic test_fine_amp;
    int upd0 = 0;
    int upd1 = 0;
    int steps = 0;
    logic [7:0] prevAmp = 8'd255;
    chSel = 1'b0;
    switches = 4'h2;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (update[0]) upd0++;
      if (update[1]) upd1++;
      if (amplitude[7:0] !== prevAmp) begin
        steps++;
        compared++;
        if (amplitude[7:0] !== prevAmp - 8'd1 || update[0] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL ramp_step got amp0=%0d upd0=%b want %0d/1", amplitude[7:0], update[0], prevAmp - 8'd1);
        end
        prevAmp = amplitude[7:0];
      end
    end
    compared++; if (phaseStep[31:0] !== 32'd11200) begin mismatched++; $display("[TB] FAIL fine_phase0 got %0d want 11200", phaseStep[31:0]); end
    compared++; if (amplitude[7:0] !== 8'd32) begin mismatched++; $display("[TB] FAIL ramp_final got %0d want 32", amplitude[7:0]); end
    compared++; if (steps != 223 || upd0 != 223) begin mismatched++; $display("[TB] FAIL ramp_count got steps=%0d upd0=%0d want 223/223", steps, upd0); end
    compared++; if (upd1 != 0 || amplitude[15:8] !== 8'd255) begin mismatched++; $display("[TB] FAIL ramp_ch1_idle got upd1=%0d amp1=%0d want 0/255", upd1, amplitude[15:8]); end
  endtask

  task automatic test_freeze;
    int upd0 = 0;
    chSel = 1'b1;
    switches = 4'hF;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (update[0]) upd0++;
    end
    compared++; if (phaseStep[31:0] !== 32'd11200 || amplitude[7:0] !== 8'd32 || upd0 != 0) begin mismatched++; $display("[TB] FAIL freeze_ch0 got phase0=%0d amp0=%0d upd0=%0d want 11200/32/0", phaseStep[31:0], amplitude[7:0], upd0); end
    compared++; if (phaseStep[63:32] !== 32'd2500) begin mismatched++; $display("[TB] FAIL ch1_fine got %0d want 2500", phaseStep[63:32]); end
    compared++; if (amplitude[15:8] !== 8'd240) begin mismatched++; $display("[TB] FAIL ch1_amp got %0d want 240", amplitude[15:8]); end
  endtask

  task automatic test_back_to_back;
    int upd0 = 0;
    chSel = 1'b0;
    switches = 4'h2;
    binc = 1'b1;
    bdec = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) begin binc = 1'b0; bdec = 1'b0; end
      if (update[0]) upd0++;
    end
    compared++; if (phaseStep[31:0] !== 32'd11200 || upd0 != 0) begin mismatched++; $display("[TB] FAIL both_buttons got phase0=%0d upd0=%0d want 11200/0", phaseStep[31:0], upd0); end
  endtask

  task automatic test_reset_mid_count;
    int upd0 = 0;
    int firstIdx = -1;
    binc = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    binc = 1'b0;
    switches = 4'h0;
    chSel = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (phaseStep !== {32'd10000, 32'd10000}) begin mismatched++; $display("[TB] FAIL midcount_phase got %0d/%0d want 10000/10000", phaseStep[63:32], phaseStep[31:0]); end
    compared++; if (amplitude !== 16'hFFFF || update !== 2'b00) begin mismatched++; $display("[TB] FAIL midcount_amp_upd got %h/%b want ffff/00", amplitude, update); end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (update[0]) upd0++;
    end
    compared++; if (upd0 != 0 || phaseStep[31:0] !== 32'd10000) begin mismatched++; $display("[TB] FAIL midcount_discard got upd0=%0d phase0=%0d want 0/10000", upd0, phaseStep[31:0]); end
    binc = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    upd0 = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (update[0]) begin
        upd0++;
        if (firstIdx < 0) firstIdx = i;
      end
    end
    compared++; if (upd0 != 1 || firstIdx != 8) begin mismatched++; $display("[TB] FAIL held_through_reset got pulses=%0d at %0d want 1 at 8", upd0, firstIdx); end
    compared++; if (phaseStep[31:0] !== 32'd11000) begin mismatched++; $display("[TB] FAIL held_phase0 got %0d want 11000", phaseStep[31:0]); end
    binc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_max_clamp;
    reset = 1'b1;
    switches = 4'h0;
    chSel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 989; i++) pressButton(1'b1, 7, 7);
    compared++; if (phaseStep[31:0] !== 32'd999000) begin mismatched++; $display("[TB] FAIL max_approach got %0d want 999000", phaseStep[31:0]); end
    switches = 4'h5;
    repeat (3) @(negedge clk);
    compared++; if (phaseStep[31:0] !== 32'd999500) begin mismatched++; $display("[TB] FAIL max_fine got %0d want 999500", phaseStep[31:0]); end
    pressButton(1'b1, 7, 7);
    compared++; if (phaseStep[31:0] !== 32'd1000000) begin mismatched++; $display("[TB] FAIL max_out_clamp got %0d want 1000000", phaseStep[31:0]); end
    pressButton(1'b1, 7, 7);
    switches = 4'h0;
    repeat (3) @(negedge clk);
    compared++; if (phaseStep[31:0] !== 32'd1000000) begin mismatched++; $display("[TB] FAIL max_base_clamp got %0d want 1000000", phaseStep[31:0]); end
    pressButton(1'b0, 7, 7);
    compared++; if (phaseStep[31:0] !== 32'd999000) begin mismatched++; $display("[TB] FAIL max_dec got %0d want 999000", phaseStep[31:0]); end
  endtask

  initial begin
    test_reset();
    test_inc_press();
    test_dec_clamp();
    test_fine_amp();
    test_freeze();
    test_back_to_back();
    test_reset_mid_count();
    test_max_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
